// File: rtl/sub_div_seq_if.sv
// Handshake/result bundle for the sub_div_seq repeated-subtraction divider.
// The abort signal exists only when SUB_DIV_ABORT_EN is defined.
interface sub_div_seq_if;
   localparam int unsigned W = 4;

   logic         start;
   logic [W-1:0] dividend;
   logic [W-1:0] divisor;
   logic         busy;
   logic         done;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         err;
`ifdef SUB_DIV_ABORT_EN
   logic         abort;

   modport master (
      output start, dividend, divisor, abort,
      input  busy, done, quotient, remainder, err
   );

   modport slave (
      input  start, dividend, divisor, abort,
      output busy, done, quotient, remainder, err
   );
`else
   modport master (
      output start, dividend, divisor,
      input  busy, done, quotient, remainder, err
   );

   modport slave (
      input  start, dividend, divisor,
      output busy, done, quotient, remainder, err
   );
`endif
endinterface

// File: rtl/sub_div_seq.sv
// 4-bit unsigned divider that sequences the 4-bit subtractor once per clock.
// Define SUB_DIV_ABORT_EN to add the abort input that cancels a running divide.

// Subtractor: s2 is |a-b|, ctrl is the borrow flag (a<b).
module sub4 (
   input  logic [3:0] a,
   input  logic [3:0] b,
   output logic [3:0] s2,
   output logic       ctrl
);
   always_comb begin
      ctrl = (a < b);
      s2   = ctrl ? (b - a) : (a - b);
   end
endmodule

module sub_div_seq (
   input  logic           clk,
   input  logic           rst_n,
   sub_div_seq_if.slave   io
);
   localparam int unsigned W = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   state_e       state_q, state_d;
   logic [W-1:0] r_q, r_d;
   logic [W-1:0] d_q, d_d;
   logic [W-1:0] q_q, q_d;
   logic [W-1:0] quo_q, quo_d;
   logic [W-1:0] rem_q, rem_d;
   logic         err_q, err_d;
   logic         busy_q, busy_d;
   logic         done_q, done_d;

   logic [W-1:0] mag_c;
   logic         borrow_c;
   logic         abort_c;

   sub4 u_sub (
      .a    (r_q),
      .b    (d_q),
      .s2   (mag_c),
      .ctrl (borrow_c)
   );

`ifdef SUB_DIV_ABORT_EN
   assign abort_c = io.abort;
`else
   assign abort_c = 1'b0;
`endif

   // State register and all datapath/result flops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         r_q     <= '0;
         d_q     <= '0;
         q_q     <= '0;
         quo_q   <= '0;
         rem_q   <= '0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         r_q     <= r_d;
         d_q     <= d_d;
         q_q     <= q_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         err_q   <= err_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // Next-state, datapath and result-load logic.
   always_comb begin
      state_d = state_q;
      r_d     = r_q;
      d_d     = d_q;
      q_d     = q_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
      err_d   = err_q;

      case (state_q)
         ST_IDLE: begin
            if (io.start) begin
               r_d     = io.dividend;
               d_d     = io.divisor;
               q_d     = '0;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (abort_c) begin
               state_d = ST_IDLE;
            end else if (d_q == '0) begin
               quo_d   = '0;
               rem_d   = r_q;
               err_d   = 1'b1;
               state_d = ST_DONE;
            end else if (borrow_c) begin
               quo_d   = q_q;
               rem_d   = r_q;
               err_d   = 1'b0;
               state_d = ST_DONE;
            end else begin
               // Commit only borrow-free subtractions, so R never wraps.
               r_d = mag_c;
               q_d = q_q + W'(1);
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
      done_d = (state_d == ST_DONE);
   end

   assign io.busy      = busy_q;
   assign io.done      = done_q;
   assign io.quotient  = quo_q;
   assign io.remainder = rem_q;
   assign io.err       = err_q;
endmodule

// File: tb/tb_sub_div_seq.sv
// Directed self-checking bench for sub_div_seq (abort steps need SUB_DIV_ABORT_EN).
module tb_sub_div_seq;
   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   sub_div_seq_if io ();

   sub_div_seq dut (
      .clk   (clk),
      .rst_n (rst_n),
      .io    (io)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Issue one divide from IDLE (#1 after an edge) and check latency and results.
   task automatic do_div(input string tag, input logic [3:0] a, input logic [3:0] b,
                         input int exp_cyc, input logic [3:0] exp_q,
                         input logic [3:0] exp_r, input logic exp_err);
      int cyc;
      cyc = 0;
      io.start    = 1'b1;
      io.dividend = a;
      io.divisor  = b;
      @(posedge clk); #1;
      io.start    = 1'b0;
      io.dividend = ~a;
      io.divisor  = ~b;
      check({tag, " busy_c0"}, 32'(io.busy), 32'd1);
      while (!io.done && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
         if (!io.done) check({tag, " busy_run"}, 32'(io.busy), 32'd1);
      end
      check({tag, " done_cycle"}, 32'(cyc), 32'(exp_cyc));
      check({tag, " quotient"}, 32'(io.quotient), 32'(exp_q));
      check({tag, " remainder"}, 32'(io.remainder), 32'(exp_r));
      check({tag, " err"}, 32'(io.err), 32'(exp_err));
      check({tag, " busy_done"}, 32'(io.busy), 32'd1);
      @(posedge clk); #1;
      check({tag, " done_pulse"}, 32'(io.done), 32'd0);
      check({tag, " busy_fall"}, 32'(io.busy), 32'd0);
   endtask

   initial begin
      int n_done;
      int done_at;
      checks      = 0;
      errors      = 0;
      rst_n       = 1'b0;
      io.start    = 1'b0;
      io.dividend = 4'd0;
      io.divisor  = 4'd0;
`ifdef SUB_DIV_ABORT_EN
      io.abort    = 1'b0;
`endif
      #1;
      check("rst busy", 32'(io.busy), 32'd0);
      check("rst done", 32'(io.done), 32'd0);
      check("rst quotient", 32'(io.quotient), 32'd0);
      check("rst remainder", 32'(io.remainder), 32'd0);
      check("rst err", 32'(io.err), 32'd0);
      #20 rst_n = 1'b1;
      @(posedge clk); #1;

      do_div("13/4", 4'd13, 4'd4, 4, 4'd3, 4'd1, 1'b0);
      do_div("15/1", 4'd15, 4'd1, 16, 4'd15, 4'd0, 1'b0);
      do_div("3/7", 4'd3, 4'd7, 1, 4'd0, 4'd3, 1'b0);
      do_div("0/5", 4'd0, 4'd5, 1, 4'd0, 4'd0, 1'b0);
      do_div("9/0", 4'd9, 4'd0, 1, 4'd0, 4'd9, 1'b1);
      do_div("8/2", 4'd8, 4'd2, 5, 4'd4, 4'd0, 1'b0);

      // 12/3 with a 1/1 start re-pulsed in cycle 2: must be ignored.
      io.start    = 1'b1;
      io.dividend = 4'd12;
      io.divisor  = 4'd3;
      @(posedge clk); #1;
      io.start = 1'b0;
      n_done   = 0;
      done_at  = -1;
      for (int c = 1; c <= 12; c++) begin
         @(posedge clk); #1;
         if (c == 2) begin
            io.start    = 1'b1;
            io.dividend = 4'd1;
            io.divisor  = 4'd1;
         end else begin
            io.start = 1'b0;
         end
         if (io.done) begin
            n_done++;
            if (done_at < 0) done_at = c;
         end
      end
      check("restart done_count", 32'(n_done), 32'd1);
      check("restart done_cycle", 32'(done_at), 32'd5);
      check("restart quotient", 32'(io.quotient), 32'd4);
      check("restart remainder", 32'(io.remainder), 32'd0);
      check("restart busy", 32'(io.busy), 32'd0);

`ifdef SUB_DIV_ABORT_EN
      do_div("7/2", 4'd7, 4'd2, 4, 4'd3, 4'd1, 1'b0);
      io.start    = 1'b1;
      io.dividend = 4'd14;
      io.divisor  = 4'd2;
      @(posedge clk); #1;
      io.start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      io.abort = 1'b1;
      @(posedge clk); #1;
      io.abort = 1'b0;
      check("abort busy", 32'(io.busy), 32'd0);
      check("abort done", 32'(io.done), 32'd0);
      n_done = 0;
      for (int c = 0; c < 12; c++) begin
         @(posedge clk); #1;
         if (io.done) n_done++;
      end
      check("abort no_done", 32'(n_done), 32'd0);
      check("abort quotient_kept", 32'(io.quotient), 32'd3);
      check("abort remainder_kept", 32'(io.remainder), 32'd1);
      do_div("6/3", 4'd6, 4'd3, 3, 4'd2, 4'd0, 1'b0);
`endif

      // Produce nonzero outputs, then reset in cycle 2 of a 13/4 run.
      do_div("11/3", 4'd11, 4'd3, 4, 4'd3, 4'd2, 1'b0);
      io.start    = 1'b1;
      io.dividend = 4'd13;
      io.divisor  = 4'd4;
      @(posedge clk); #1;
      io.start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check("midrst busy", 32'(io.busy), 32'd0);
      check("midrst done", 32'(io.done), 32'd0);
      check("midrst quotient", 32'(io.quotient), 32'd0);
      check("midrst remainder", 32'(io.remainder), 32'd0);
      check("midrst err", 32'(io.err), 32'd0);
      #12 rst_n = 1'b1;
      n_done = 0;
      for (int c = 0; c < 8; c++) begin
         @(posedge clk); #1;
         if (io.done) n_done++;
      end
      check("midrst no_done", 32'(n_done), 32'd0);
      do_div("10/3", 4'd10, 4'd3, 4, 4'd3, 4'd1, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/sub_div_seq.md
# sub_div_seq

Multi-cycle unsigned 4-bit divider controller that sequences the team's 4-bit `Sub` subtractor. `Sub` returns the magnitude in `s2` and sets its borrow flag `ctrl` to 1 when a<b. This block computes quotient and remainder by repeated subtraction, one `Sub` evaluation per clock. It has a start/busy/done handshake and flags divide-by-zero. It sits beside the ALU datapath and reuses the existing subtractor instead of adding a dedicated divider.

## Interface
Parameters:
- none; width is fixed at 4 bits to match `Sub`.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only in IDLE.
- `dividend`  in  4  numerator; captured when `start` is accepted.
- `divisor`  in  4  denominator; captured when `start` is accepted.
- `busy`  out  1  high in RUN and DONE.
- `done`  out  1  single-cycle pulse; results valid.
- `quotient`  out  4  registered result; held until the next completion.
- `remainder`  out  4  registered result; held until the next completion.
- `err`  out  1  divide-by-zero flag; updated with each result.
- `abort`  in  1  present only with `SUB_DIV_ABORT_EN`.

## Operation
- Internal registers: working remainder `R[3:0]`, divisor `D[3:0]`, count `Q[3:0]`, and the state.
- One `Sub` instance, a=`R`, b=`D`, combinational.
- IDLE
  - `busy`=0.
  - On `start`=1: `R`<=`dividend`, `D`<=`divisor`, `Q`<=0, go to RUN.
  - On `start`=0: stay in IDLE.
- RUN, evaluated in priority order:
  - `D`==0: load outputs `quotient`=0, `remainder`=`R`, `err`=1; go to DONE.
  - `Sub` borrow=1 (`R`<`D`): load outputs `quotient`=`Q`, `remainder`=`R`, `err`=0; go to DONE.
  - Otherwise: `R`<=`Sub` magnitude, `Q`<=`Q`+1; stay in RUN.
- DONE
  - `done`=1 for exactly this one cycle.
  - Always returns to IDLE on the next edge.
- Arithmetic
  - `Q` cannot overflow: the maximum is 15 (15/1).
  - `R` never underflows, because a subtraction is committed only when borrow=0.
- `start` in RUN or DONE is ignored, with no queueing. A request must be re-presented in IDLE.
- `dividend`/`divisor` changes after acceptance have no effect.
- Output registers change only on DONE entry.

## Timing
- Reset (async assert, `rst_n`=0):
  - state=IDLE.
  - `busy`=0, `done`=0, `err`=0, `quotient`=0, `remainder`=0.
  - `R`, `D`, `Q`=0.
- Reset mid-RUN: the operation is discarded and outputs read 0 immediately, with no `done`.
- Release is synchronous to the next edge, and `start` is accepted no earlier than that edge.
- Latency: `start` accepted at edge 0; DONE is entered at edge q+1, where q is the final quotient.
  - `done` is high in cycle q+1; `busy` falls at edge q+2.
  - Divide-by-zero: DONE at edge 1.
  - Worst case (15/1): DONE at edge 16.
- Minimum spacing between accepted starts: q+3 edges.
- `busy` is high from edge 0 through the DONE cycle inclusive.

## Configuration
- `SUB_DIV_ABORT_EN` defined:
  - Adds the `abort` input.
  - `abort`=1 in RUN forces IDLE at the next edge, with no `done`.
  - Output registers keep their previous values.
  - `abort` in IDLE or DONE is ignored.
  - `abort` has priority over all RUN conditions.
- `SUB_DIV_ABORT_EN` undefined:
  - The `abort` port is not present.
  - RUN always runs to completion.

## Test plan
- 13/4: `start` at edge 0 -> `done` high in cycle 4, `quotient`=3, `remainder`=1, `err`=0; `busy` high cycles 0–4.
- 15/1 -> `done` in cycle 16, `quotient`=15, `remainder`=0. Confirms no overflow at the maximum count.
- 3/7 and 0/5 -> `done` in cycle 1, `quotient`=0, `remainder`=3 and 0 respectively.
- 9/0 -> `done` in cycle 1, `err`=1, `quotient`=0, `remainder`=9. A following 8/2 gives `err`=0, `quotient`=4, `remainder`=0.
- `start` re-pulsed with 1/1 during a 12/3 run -> the 12/3 result (`quotient`=4, `remainder`=0) is unaffected and only one `done` occurs. `rst_n` low in cycle 2 of a run -> all outputs 0 asynchronously, no `done`.
- With `SUB_DIV_ABORT_EN`: 14/2, then `abort` in cycle 3 -> IDLE at the next edge, no `done`, previous outputs unchanged. A subsequent 6/3 gives `quotient`=2, `remainder`=0.
